// File: rtl/umi_xbar.sv
// umi_xbar: non-blocking N x N UMI crossbar.
// Each output arbitrates independently (fixed priority or round-robin)
// among the inputs requesting it. The winner's fields are AND-OR muxed
// to the output with a zero-latency valid/ready pass-through. A stalled
// output (valid & ~ready) locks its grant until handshake or request drop.
module umi_xbar #(
    parameter int unsigned N  = 2,
    parameter int unsigned CW = 32,
    parameter int unsigned AW = 64,
    parameter int unsigned DW = 256
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic [1:0]      mode,
    input  logic [N*N-1:0]  mask,
    input  logic [N*N-1:0]  umi_in_request,
    input  logic [N*CW-1:0] umi_in_cmd,
    input  logic [N*AW-1:0] umi_in_dstaddr,
    input  logic [N*AW-1:0] umi_in_srcaddr,
    input  logic [N*DW-1:0] umi_in_data,
    output logic [N-1:0]    umi_in_ready,
    output logic [N-1:0]    umi_out_valid,
    output logic [N*CW-1:0] umi_out_cmd,
    output logic [N*AW-1:0] umi_out_dstaddr,
    output logic [N*AW-1:0] umi_out_srcaddr,
    output logic [N*DW-1:0] umi_out_data,
    input  logic [N-1:0]    umi_out_ready
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic           rr_mode;
    logic [N-1:0]   req    [N];
    logic [N-1:0]   grant  [N];
    logic [PW-1:0]  ptr_q  [N];
    logic [PW-1:0]  ptr_d  [N];
    logic [PW-1:0]  gidx_q [N];
    logic [PW-1:0]  gidx_d [N];
    logic [N-1:0]   lock_q;
    logic [N-1:0]   lock_d;

    assign rr_mode = (mode == 2'b10) || (mode == 2'b11);

    // Per-output arbitration: honour lock first, else fixed/round-robin pick;
    // also derive next pointer, held grant index and lock state.
    always_comb begin
        logic        found;
        int unsigned idx;
        for (int unsigned j = 0; j < N; j++) begin
            req[j]    = '0;
            grant[j]  = '0;
            ptr_d[j]  = ptr_q[j];
            gidx_d[j] = gidx_q[j];
            lock_d[j] = 1'b0;
            found     = 1'b0;
            idx       = 0;
            for (int unsigned i = 0; i < N; i++) begin
                req[j][i] = umi_in_request[j*N+i] & ~mask[j*N+i];
            end
            // A locked grant survives mode changes; it lapses only when its
            // request drops (masking counts as a drop).
            if (lock_q[j] && req[j][gidx_q[j]]) begin
                grant[j][gidx_q[j]] = 1'b1;
            end else if (rr_mode) begin
                for (int unsigned off = 0; off < N; off++) begin
                    idx = (32'(ptr_q[j]) + off) % N;
                    if (!found && req[j][idx]) begin
                        grant[j][idx] = 1'b1;
                        found         = 1'b1;
                    end
                end
            end else begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (!found && req[j][i]) begin
                        grant[j][i] = 1'b1;
                        found       = 1'b1;
                    end
                end
            end
            if (!nreset) begin
                grant[j] = '0;
            end
            for (int unsigned i = 0; i < N; i++) begin
                if (grant[j][i]) begin
                    gidx_d[j] = PW'(i);
                    if (umi_out_ready[j]) begin
                        ptr_d[j] = PW'((i + 1) % N);
                    end
                end
            end
            lock_d[j] = (|grant[j]) & ~umi_out_ready[j];
        end
    end

    // Datapath: AND-OR mux of input fields per output, ready fan-back to inputs.
    always_comb begin
        umi_out_valid   = '0;
        umi_out_cmd     = '0;
        umi_out_dstaddr = '0;
        umi_out_srcaddr = '0;
        umi_out_data    = '0;
        umi_in_ready    = '0;
        for (int unsigned j = 0; j < N; j++) begin
            umi_out_valid[j] = |grant[j];
            for (int unsigned i = 0; i < N; i++) begin
                umi_out_cmd[j*CW+:CW]     = umi_out_cmd[j*CW+:CW]
                                          | (umi_in_cmd[i*CW+:CW] & {CW{grant[j][i]}});
                umi_out_dstaddr[j*AW+:AW] = umi_out_dstaddr[j*AW+:AW]
                                          | (umi_in_dstaddr[i*AW+:AW] & {AW{grant[j][i]}});
                umi_out_srcaddr[j*AW+:AW] = umi_out_srcaddr[j*AW+:AW]
                                          | (umi_in_srcaddr[i*AW+:AW] & {AW{grant[j][i]}});
                umi_out_data[j*DW+:DW]    = umi_out_data[j*DW+:DW]
                                          | (umi_in_data[i*DW+:DW] & {DW{grant[j][i]}});
                umi_in_ready[i] = umi_in_ready[i] | (grant[j][i] & umi_out_ready[j]);
            end
        end
    end

    // State registers: round-robin pointers, held grant index and lock flags.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            lock_q <= '0;
            for (int unsigned j = 0; j < N; j++) begin
                ptr_q[j]  <= '0;
                gidx_q[j] <= '0;
            end
        end else begin
            lock_q <= lock_d;
            for (int unsigned j = 0; j < N; j++) begin
                ptr_q[j]  <= ptr_d[j];
                gidx_q[j] <= gidx_d[j];
            end
        end
    end

endmodule

// File: tb/tb_umi_xbar.sv
// tb_umi_xbar: directed self-checking bench for umi_xbar (N=4, DW=512).
module tb_umi_xbar;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 32;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 512;

    logic            clk = 1'b0;
    logic            nreset;
    logic [1:0]      mode;
    logic [N*N-1:0]  mask;
    logic [N*N-1:0]  umi_in_request;
    logic [N*CW-1:0] umi_in_cmd;
    logic [N*AW-1:0] umi_in_dstaddr;
    logic [N*AW-1:0] umi_in_srcaddr;
    logic [N*DW-1:0] umi_in_data;
    logic [N-1:0]    umi_in_ready;
    logic [N-1:0]    umi_out_valid;
    logic [N*CW-1:0] umi_out_cmd;
    logic [N*AW-1:0] umi_out_dstaddr;
    logic [N*AW-1:0] umi_out_srcaddr;
    logic [N*DW-1:0] umi_out_data;
    logic [N-1:0]    umi_out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    umi_xbar #(.N(N), .CW(CW), .AW(AW), .DW(DW)) dut (
        .clk             (clk),
        .nreset          (nreset),
        .mode            (mode),
        .mask            (mask),
        .umi_in_request  (umi_in_request),
        .umi_in_cmd      (umi_in_cmd),
        .umi_in_dstaddr  (umi_in_dstaddr),
        .umi_in_srcaddr  (umi_in_srcaddr),
        .umi_in_data     (umi_in_data),
        .umi_in_ready    (umi_in_ready),
        .umi_out_valid   (umi_out_valid),
        .umi_out_cmd     (umi_out_cmd),
        .umi_out_dstaddr (umi_out_dstaddr),
        .umi_out_srcaddr (umi_out_srcaddr),
        .umi_out_data    (umi_out_data),
        .umi_out_ready   (umi_out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] cmd_of(input int unsigned i);
        return 32'hC000_0000 + 32'(i);
    endfunction

    function automatic logic [DW-1:0] data_of(input int unsigned i);
        logic [31:0] w;
        w = 32'hA000_0000 + 32'(i);
        return {16{w}};
    endfunction

    task automatic init_fields();
        for (int unsigned i = 0; i < N; i++) begin
            umi_in_cmd[i*CW+:CW]     = cmd_of(i);
            umi_in_dstaddr[i*AW+:AW] = 64'hD0 + 64'(i);
            umi_in_srcaddr[i*AW+:AW] = 64'h50 + 64'(i);
            umi_in_data[i*DW+:DW]    = data_of(i);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] rdy;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] rr_seq [4];

        // Reset state with a request pending
        nreset         = 1'b0;
        mode           = 2'b10;
        mask           = '0;
        umi_out_ready  = '1;
        umi_in_request = 16'h0001;
        init_fields();
        #3;
        check("rst_valid", umi_out_valid, 4'b0000);
        check("rst_ready", umi_in_ready, 4'b0000);
        check("rst_cmd0", umi_out_cmd[0+:CW], '0);
        check("rst_data0", umi_out_data[0+:DW], '0);
        umi_in_request = '0;
        #9 nreset = 1'b1;

        // Single transfer: input 2 -> output 1
        tick();
        umi_in_cmd[2*CW+:CW]     = 32'h5;
        umi_in_dstaddr[2*AW+:AW] = 64'h0000_0100_0000_0000;
        umi_in_srcaddr[2*AW+:AW] = 64'h1234;
        umi_in_data[2*DW+:DW]    = 512'hAB;
        umi_in_request           = 16'h0040;
        #1;
        check("t1_valid", umi_out_valid, 4'b0010);
        check("t1_cmd", umi_out_cmd[1*CW+:CW], 32'h5);
        check("t1_dst", umi_out_dstaddr[1*AW+:AW], 64'h0000_0100_0000_0000);
        check("t1_src", umi_out_srcaddr[1*AW+:AW], 64'h1234);
        check("t1_data", umi_out_data[1*DW+:DW], 512'hAB);
        check("t1_ready", umi_in_ready, 4'b0100);
        tick();
        umi_in_request = '0;
        init_fields();

        // Round-robin rotation among inputs 0,1,3 on output 0
        rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b1000; rr_seq[3] = 4'b0001;
        umi_in_request = 16'h000B;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_ready", umi_in_ready, rr_seq[k]);
            tick();
        end
        // Fixed priority: input 0 every cycle
        mode = 2'b00;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("fp_ready", umi_in_ready, 4'b0001);
            check("fp_cmd", umi_out_cmd[0+:CW], cmd_of(0));
            tick();
        end
        umi_in_request = '0;
        mode           = 2'b10;

        // Lock: inputs 1,3 -> output 2 with output 2 stalled
        umi_out_ready  = 4'b1011;
        umi_in_request = 16'h0A00;
        #1;
        check("lk_valid", umi_out_valid, 4'b0100);
        check("lk_ready0", umi_in_ready, 4'b0000);
        check("lk_cmd0", umi_out_cmd[2*CW+:CW], cmd_of(1));
        tick();
        umi_in_request = 16'h0B00;   // input 0 joins; lock must keep input 1
        for (int k = 0; k < 2; k++) begin
            #1;
            check("lk_ready", umi_in_ready, 4'b0000);
            check("lk_cmd", umi_out_cmd[2*CW+:CW], cmd_of(1));
            check("lk_data", umi_out_data[2*DW+:DW], data_of(1));
            tick();
        end
        umi_out_ready = 4'b1111;
        #1;
        check("lk_xfer_ready", umi_in_ready, 4'b0010);
        check("lk_xfer_data", umi_out_data[2*DW+:DW], data_of(1));
        tick();
        umi_in_request = 16'h0900;   // input 1 done; ptr now 2 so input 3 wins
        #1;
        check("lk_next_ready", umi_in_ready, 4'b1000);
        check("lk_next_cmd", umi_out_cmd[2*CW+:CW], cmd_of(3));
        tick();
        umi_in_request = '0;

        // Concurrent transfers: input i -> output (i+1)%4, random ready
        umi_in_request = 16'h4218;
        for (int k = 0; k < 4; k++) begin
            rdy           = 4'($urandom_range(0, 15));
            umi_out_ready = rdy;
            #1;
            check("cc_valid", umi_out_valid, 4'b1111);
            for (int unsigned j = 0; j < N; j++) begin
                check("cc_data", umi_out_data[j*DW+:DW], data_of((j + 3) % N));
            end
            for (int unsigned i = 0; i < N; i++) begin
                exp_rdy[i] = rdy[(i + 1) % N];
            end
            check("cc_ready", umi_in_ready, exp_rdy);
            tick();
        end
        umi_in_request = '0;
        umi_out_ready  = '1;

        // Mask blocks input 3 from output 0
        mask           = 16'h0008;
        umi_in_request = 16'h0008;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("mk_valid", umi_out_valid, 4'b0000);
            check("mk_ready", umi_in_ready, 4'b0000);
            tick();
        end
        mask = '0;
        #1;
        check("mk_clr_valid", umi_out_valid, 4'b0001);
        check("mk_clr_ready", umi_in_ready, 4'b1000);
        tick();
        umi_in_request = '0;

        // Reset mid-transfer: move ptr[0] to 2 first
        umi_in_request = 16'h0002;
        #1;
        check("rs_pre_ready", umi_in_ready, 4'b0010);
        tick();
        umi_in_request = 16'h0005;
        umi_out_ready  = 4'b0000;
        #1;
        check("rs_pre_valid", umi_out_valid, 4'b0001);
        check("rs_pre_cmd", umi_out_cmd[0+:CW], cmd_of(2));
        #2 nreset = 1'b0;
        umi_out_ready = 4'b1111;
        #1;
        check("rs_valid", umi_out_valid, 4'b0000);
        check("rs_ready", umi_in_ready, 4'b0000);
        check("rs_cmd", umi_out_cmd[0+:CW], '0);
        check("rs_data", umi_out_data[0+:DW], '0);
        tick();
        check("rs_hold_valid", umi_out_valid, 4'b0000);
        umi_in_request = '0;
        @(negedge clk);
        nreset = 1'b1;
        tick();
        umi_in_request = 16'h0005;
        #1;
        check("rs_post_ready", umi_in_ready, 4'b0001);
        check("rs_post_cmd", umi_out_cmd[0+:CW], cmd_of(0));
        tick();
        umi_in_request = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/umi_xbar.md
Name: umi_xbar

Overview:
- Non-blocking N x N UMI crossbar: each input port raises per-output requests, and each output port arbitrates independently among requesting inputs.
- The granted input's cmd/dstaddr/srcaddr/data is muxed combinationally to that output with valid/ready handshake pass-through.
- Sits between UMI agents/hosts in the fabric; request decode from address is done outside the block.

Parameters:
- N, 2, number of input and output ports (test config 4)
- CW, 32, command width
- AW, 64, address width
- DW, 256, data width (test config 512)

Ports:
- clk  input  1  clock
- nreset  input  1  asynchronous active-low reset
- mode  input  2  arbitration mode: 2'b00/2'b01 fixed priority, 2'b10/2'b11 round-robin
- mask  input  N*N  mask[j*N+i]=1 blocks input i from output j
- umi_in_request  input  N*N  bit [j*N+i]: input i requests output j (at most one j per i)
- umi_in_cmd  input  N*CW  per-input command, slice i at [i*CW+:CW]
- umi_in_dstaddr  input  N*AW  per-input destination address
- umi_in_srcaddr  input  N*AW  per-input source address
- umi_in_data  input  N*DW  per-input data
- umi_in_ready  output  N  input i accepted this cycle
- umi_out_valid  output  N  output j valid
- umi_out_cmd  output  N*CW  output cmd
- umi_out_dstaddr  output  N*AW  output dstaddr
- umi_out_srcaddr  output  N*AW  output srcaddr
- umi_out_data  output  N*DW  output data
- umi_out_ready  input  N  output j sink ready

Behaviour:
- Effective request: req[j][i] = umi_in_request[j*N+i] & ~mask[j*N+i].
- Per output j, one-hot grant g[j][i] selected from req[j][*].
  - Fixed priority: lowest i wins.
  - Round-robin: search starts at ptr[j], wrapping modulo N. ptr resets to 0; after a handshake on output j by input k, ptr[j] <= (k+1) mod N.
- Lock: if umi_out_valid[j] & ~umi_out_ready[j], lock[j] <= 1 and the grant is held to the same input next cycle, regardless of other requests. lock[j] clears on handshake or when the granted request drops.
- umi_out_valid[j] = |g[j].
- Output fields = AND-OR mux of input fields by g[j]. All-zero outputs when no grant.
- umi_in_ready[i] = OR_j(g[j][i] & umi_out_ready[j]). An input with no request gets ready=0.
- Zero-latency combinational datapath. Registers: ptr[j] (log2 N bits) and lock[j] per output.
- Transfer on output j occurs when valid & ready. A mid-burst lock change is not allowed.
- Different outputs operate concurrently with no interaction. Simultaneous requests to different outputs all proceed in the same cycle.
- Reset (nreset low, async): ptr=0 and lock=0. All grants forced 0, so umi_out_valid=0, umi_in_ready=0 and out fields=0 while in reset. Deassertion takes effect on the next clk edge evaluation.
- Mode change while locked: the lock is still honoured, and the new mode applies from the next arbitration.
- Request to a masked output: never granted, and in_ready stays 0.

Test Plan:
- N=4, round-robin, ready=1: input 2 requests output 1 with cmd=0x5, dst=0x0000_0100_0000_0000, data=0xAB -> same cycle out_valid[1]=1, out_cmd[1]=0x5, out_data[1]=0xAB, in_ready[2]=1, all other outputs invalid.
- Inputs 0, 1, 3 all request output 0 continuously, mode=2'b10, ready=1 -> grants rotate 0, 1, 3, 0, ... one per cycle. With mode=2'b00, input 0 wins every cycle.
- Output 2 ready=0 for 3 cycles while inputs 1 and 3 request it -> grant held on the first winner with stable cmd/data and in_ready=0. When ready rises, that input transfers; the other input is granted next cycle.
- All four inputs target distinct outputs (i -> (i+1)%4), random ready -> four concurrent transfers, and each output's received data matches its source exactly.
- mask[0*4+3]=1, input 3 requests output 0 -> out_valid[0]=0, in_ready[3]=0 indefinitely. Clearing the mask -> transfer occurs.
- Assert nreset low mid-transfer with requests pending -> out_valid=0 and in_ready=0 immediately. After release, ptr restarts at 0, so input 0 wins first in round-robin.
